vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_change_gen.sv | 21 ++
 rtl/vend_ctrl.sv | 160 ++++++++++++++++
 tb/tb_vend_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin codes, controller states and coin values for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_5C  = 2'd0,
        COIN_10C = 2'd1,
        COIN_25C = 2'd2,
        COIN_BAD = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam int COIN5  = 5;
    localparam int COIN10 = 10;
    localparam int COIN25 = 25;

    function automatic logic [4:0] coin_value(input coin_t c);
        case (c)
            COIN_5C:  return 5'(COIN5);
            COIN_10C: return 5'(COIN10);
            COIN_25C: return 5'(COIN25);
            default:  return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change coin picker: largest coin not exceeding the remaining credit.
// Purely combinational; the caller only consults it while credit is nonzero.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          chg_coin
);

    always_comb begin
        chg_coin = COIN_5C;
        if (credit >= CREDIT_W'(COIN25)) begin
            chg_coin = COIN_25C;
        end else if (credit >= CREDIT_W'(COIN10)) begin
            chg_coin = COIN_10C;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, product release handshake and greedy change payout.
// Coin/select responses one cycle after the pulse; vend_vld/chg_vld held until their ack.
// Define VEND_CANCEL_EN to let cancel refund the full credit from CREDIT.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 95,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin_vld,
    input  logic [1:0]                   coin_sel,
    input  logic                         sel_vld,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_idx,
    input  logic                         cancel,
    output logic                         vend_vld,
    output logic [$clog2(NUM_ITEMS)-1:0] vend_idx,
    input  logic                         vend_ack,
    output logic                         chg_vld,
    output logic [1:0]                   chg_coin,
    input  logic                         chg_ack,
    output logic [CREDIT_W-1:0]          credit,
    output logic [NUM_ITEMS-1:0]         sold_out,
    output logic                         coin_reject,
    output logic                         sel_err,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_ITEMS);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]    vend_idx_q, vend_idx_d;
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;
    logic                dec_stock;
    logic                cancel_req;
    logic                coin_ok;
    logic                sel_in_range;
    logic                sel_empty;
    logic [CREDIT_W:0]   coin_sum;
    logic [1:0]          gen_coin;
    logic [CREDIT_W-1:0] chg_val;

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_req    = 1'b0;
`endif

    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .credit   (credit_q),
        .chg_coin (gen_coin)
    );

    assign chg_val  = CREDIT_W'(coin_value(coin_t'(gen_coin)));
    assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_t'(coin_sel)));
    assign coin_ok  = (coin_t'(coin_sel) != COIN_BAD) &&
                      (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    // Out-of-range indices (non power-of-two NUM_ITEMS) must not touch the stock array.
    assign sel_in_range = (int'(sel_idx) < NUM_ITEMS);
    assign sel_empty    = sel_in_range ? (stock_q[sel_idx] == '0) : 1'b1;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_idx_d    = vend_idx_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        dec_stock     = 1'b0;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (coin_vld) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (state_q == ST_CREDIT && cancel_req) begin
                    state_d = ST_CHANGE;
                end else if (sel_vld && credit_q >= CREDIT_W'(PRICE)) begin
                    if (sel_empty) begin
                        sel_err_d = 1'b1;
                    end else begin
                        state_d    = ST_VEND;
                        vend_idx_d = sel_idx;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_vld;
                if (vend_ack) begin
                    credit_d  = credit_q - CREDIT_W'(PRICE);
                    dec_stock = 1'b1;
                    state_d   = (credit_q == CREDIT_W'(PRICE)) ? ST_IDLE : ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_vld;
                if (chg_ack) begin
                    credit_d = credit_q - chg_val;
                    state_d  = (credit_q == chg_val) ? ST_IDLE : ST_CHANGE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            vend_idx_q    <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_idx_q    <= vend_idx_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else if (dec_stock && stock_q[vend_idx_q] != '0) begin
            stock_q[vend_idx_q] <= stock_q[vend_idx_q] - STOCK_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_sold_out
        assign sold_out[g] = (stock_q[g] == '0);
    end

    assign vend_vld    = (state_q == ST_VEND);
    assign vend_idx    = vend_idx_q;
    assign chg_vld     = (state_q == ST_CHANGE);
    assign chg_coin    = chg_vld ? gen_coin : 2'd0;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;
    assign busy        = vend_vld | chg_vld;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: stimulus pushes expected handshake events, a negedge monitor pops and compares.
module tb_vend_ctrl;

    localparam int EV_VEND = 0;
    localparam int EV_CHG  = 1;
    localparam int EV_REJ  = 2;
    localparam int EV_SERR = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_vld = 1'b0;
    logic [1:0] coin_sel = 2'd0;
    logic       sel_vld = 1'b0;
    logic [1:0] sel_idx = 2'd0;
    logic       cancel = 1'b0;
    logic       vend_vld;
    logic [1:0] vend_idx;
    logic       vend_ack = 1'b0;
    logic       chg_vld;
    logic [1:0] chg_coin;
    logic       chg_ack = 1'b0;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       coin_reject;
    logic       sel_err;
    logic       busy;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    vend_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .coin_vld    (coin_vld),
        .coin_sel    (coin_sel),
        .sel_vld     (sel_vld),
        .sel_idx     (sel_idx),
        .cancel      (cancel),
        .vend_vld    (vend_vld),
        .vend_idx    (vend_idx),
        .vend_ack    (vend_ack),
        .chg_vld     (chg_vld),
        .chg_coin    (chg_coin),
        .chg_ack     (chg_ack),
        .credit      (credit),
        .sold_out    (sold_out),
        .coin_reject (coin_reject),
        .sel_err     (sel_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d val=%0d required=none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                errors++;
                $display("FAIL event actual kind=%0d val=%0d required kind=%0d val=%0d",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: one event per new vend offer, per new change coin offered, per reject/error pulse.
    logic vend_vld_p = 1'b0;
    logic chg_vld_p  = 1'b0;
    logic chg_ack_p  = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (vend_vld && !vend_vld_p)            got(EV_VEND, int'(vend_idx));
            if (chg_vld && (!chg_vld_p || chg_ack_p)) got(EV_CHG, int'(chg_coin));
            if (coin_reject)                        got(EV_REJ, 0);
            if (sel_err)                            got(EV_SERR, 0);
        end
        vend_vld_p = vend_vld;
        chg_vld_p  = chg_vld;
        chg_ack_p  = chg_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_vld = 1'b1;
        coin_sel = c;
        tick();
        coin_vld = 1'b0;
        coin_sel = 2'd0;
    endtask

    task automatic sel(input logic [1:0] i);
        sel_vld = 1'b1;
        sel_idx = i;
        tick();
        sel_vld = 1'b0;
    endtask

    task automatic ack_vend();
        int n = 0;
        while (!vend_vld && n < 10) begin
            tick();
            n++;
        end
        chk("vend_wait", vend_vld, 1);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
    endtask

    task automatic drain_change();
        int n = 0;
        while (chg_vld && n < 20) begin
            chg_ack = 1'b1;
            tick();
            chg_ack = 1'b0;
            n++;
        end
        chk("change_done", chg_vld, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_credit", credit, 0);
        chk("rst_vend_vld", vend_vld, 0);
        chk("rst_vend_idx", vend_idx, 0);
        chk("rst_chg_vld", chg_vld, 0);
        chk("rst_chg_coin", chg_coin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sold_out", sold_out, 0);
        chk("rst_pulses", {coin_reject, sel_err}, 0);
        reset = 1'b0;
        tick();

        // 25c, select 0, held offer, ack: exact credit means straight back to idle
        coin(2'd2);
        chk("t1_credit25", credit, 25);
        expect_ev(EV_VEND, 0);
        sel(2'd0);
        chk("t1_vend_vld", vend_vld, 1);
        chk("t1_busy", busy, 1);
        tick();
        tick();
        chk("t1_vend_hold", {vend_vld, vend_idx}, {1'b1, 2'd0});
        ack_vend();
        chk("t1_credit0", credit, 0);
        chk("t1_idle", {vend_vld, chg_vld, busy}, 0);
        chk("t1_stock0", dut.stock_q[0], 7);

        // 25+10+5, select 1 -> change 10 then 5; coin during CHANGE rejected
        coin(2'd2);
        coin(2'd1);
        coin(2'd0);
        chk("t2_credit40", credit, 40);
        expect_ev(EV_VEND, 1);
        expect_ev(EV_CHG, 1);
        sel(2'd1);
        ack_vend();
        chk("t2_credit15", credit, 15);
        chk("t2_chg", {chg_vld, chg_coin, busy}, {1'b1, 2'd1, 1'b1});
        expect_ev(EV_REJ, 0);
        coin(2'd0);
        chk("t2_credit_kept", credit, 15);
        expect_ev(EV_CHG, 0);
        chg_ack = 1'b1;
        tick();
        chg_ack = 1'b0;
        chk("t2_credit5", credit, 5);
        chk("t2_coin5", chg_coin, 0);
        drain_change();
        chk("t2_final", {credit, busy}, 0);

        // Underpriced select ignored, stray acks ignored, overflow/invalid coins rejected
        coin(2'd1);
        sel(2'd0);
        chk("t3_underpriced", {vend_vld, credit}, {1'b0, 8'd10});
        vend_ack = 1'b1;
        chg_ack  = 1'b1;
        tick();
        vend_ack = 1'b0;
        chg_ack  = 1'b0;
        chk("t3_stray_ack", credit, 10);
        coin(2'd2);
        coin(2'd2);
        coin(2'd2);
        coin(2'd0);
        chk("t3_credit90", credit, 90);
        expect_ev(EV_REJ, 0);
        coin(2'd1);
        chk("t3_over_max", credit, 90);
        expect_ev(EV_REJ, 0);
        coin(2'd3);
        chk("t3_bad_coin", credit, 90);
        coin_vld = 1'b1;
        coin_sel = 2'd0;
        sel_vld  = 1'b1;
        sel_idx  = 2'd3;
        tick();
        coin_vld = 1'b0;
        sel_vld  = 1'b0;
        chk("t3_coin_prio", {vend_vld, credit}, {1'b0, 8'd95});
        expect_ev(EV_VEND, 3);
        expect_ev(EV_CHG, 2);
        expect_ev(EV_CHG, 2);
        expect_ev(EV_CHG, 1);
        expect_ev(EV_CHG, 1);
        sel(2'd3);
        ack_vend();
        chk("t3_credit70", credit, 70);
        drain_change();

        // Drain item 2 then select it again
        for (int i = 0; i < 8; i++) begin
            coin(2'd2);
            expect_ev(EV_VEND, 2);
            sel(2'd2);
            ack_vend();
        end
        chk("t4_sold_out", sold_out, 4'b0100);
        coin(2'd2);
        expect_ev(EV_SERR, 0);
        sel(2'd2);
        chk("t4_unchanged", {vend_vld, busy, credit}, {2'b00, 8'd25});
        tick();
        chk("t4_sel_err_pulse", sel_err, 0);
        expect_ev(EV_VEND, 0);
        sel(2'd0);
        ack_vend();

        // Cancel with 40c credit
        coin(2'd2);
        coin(2'd1);
        coin(2'd0);
`ifdef VEND_CANCEL_EN
        expect_ev(EV_CHG, 2);
        expect_ev(EV_CHG, 1);
        expect_ev(EV_CHG, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t5_cancel_chg", {chg_vld, chg_coin}, {1'b1, 2'd2});
        drain_change();
        chk("t5_refunded", credit, 0);
`else
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        chk("t5_cancel_ignored", {busy, credit}, {1'b0, 8'd40});
        expect_ev(EV_VEND, 0);
        expect_ev(EV_CHG, 1);
        expect_ev(EV_CHG, 0);
        sel(2'd0);
        ack_vend();
        drain_change();
`endif

        // Reset while paying change
        coin(2'd2);
        coin(2'd1);
        coin(2'd0);
        expect_ev(EV_VEND, 1);
        expect_ev(EV_CHG, 1);
        sel(2'd1);
        ack_vend();
        chk("t6_in_change", chg_vld, 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_chg_vld_drop", chg_vld, 0);
        chk("t6_credit0", credit, 0);
        chk("t6_sold_out", sold_out, 0);
        chk("t6_stock1", dut.stock_q[1], 8);
        chk("t6_stock2", dut.stock_q[2], 8);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        tick();
        chk("t6_quiet", {vend_vld, chg_vld, busy, coin_reject, sel_err}, 0);

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
